// File: rtl/regfile_readback.sv
// Register file with two bypassed combinational read ports and a handshaked
// readback sequencer that streams every register out, one beat per transfer.
module regfile_readback #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NREG     = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             regwrite,
  input  logic [AW-1:0]    writereg,
  input  logic [WIDTH-1:0] writedata,
  input  logic [AW-1:0]    readreg1,
  input  logic [AW-1:0]    readreg2,
  output logic [WIDTH-1:0] readdata1,
  output logic [WIDTH-1:0] readdata2,
  input  logic             dumpreq,
  input  logic             dumpready,
  output logic             dumpvalid,
  output logic [AW-1:0]    dumpaddr,
  output logic [WIDTH-1:0] dumpdata,
  output logic             dumpdone,
  output logic             busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam bit            HAS_ZERO = (ZERO_REG != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    index_q, index_d;
  logic [AW-1:0]    dumpaddr_d;
  logic [WIDTH-1:0] dumpdata_d;
  logic             dumpvalid_d, dumpdone_d, busy_d;

  logic [WIDTH-1:0] regs [NREG];
  logic             wr_en;
  logic [WIDTH-1:0] load_data;

  // Writes to the hardwired zero register are dropped
  always_comb begin
    wr_en = regwrite && !(HAS_ZERO && (writereg == '0));
  end

  // Register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[writereg] <= writedata;
    end
  end

  // Bypassed read ports; zero register wins over bypass
  always_comb begin
    if (HAS_ZERO && (readreg1 == '0)) begin
      readdata1 = '0;
    end else if (regwrite && (writereg == readreg1)) begin
      readdata1 = writedata;
    end else begin
      readdata1 = regs[readreg1];
    end

    if (HAS_ZERO && (readreg2 == '0)) begin
      readdata2 = '0;
    end else if (regwrite && (writereg == readreg2)) begin
      readdata2 = writedata;
    end else begin
      readdata2 = regs[readreg2];
    end
  end

  // Bypassed read of the register the sequencer is about to capture
  always_comb begin
    if (HAS_ZERO && (index_q == '0)) begin
      load_data = '0;
    end else if (regwrite && (writereg == index_q)) begin
      load_data = writedata;
    end else begin
      load_data = regs[index_q];
    end
  end

  // Sequencer state and registered dump outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      index_q   <= '0;
      dumpaddr  <= '0;
      dumpdata  <= '0;
      dumpvalid <= 1'b0;
      dumpdone  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      dumpaddr  <= dumpaddr_d;
      dumpdata  <= dumpdata_d;
      dumpvalid <= dumpvalid_d;
      dumpdone  <= dumpdone_d;
      busy      <= busy_d;
    end
  end

  // Sequencer next state; status flags derive from the state being entered
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    dumpaddr_d = dumpaddr;
    dumpdata_d = dumpdata;

    case (state_q)
      IDLE: begin
        if (dumpreq) begin
          index_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        dumpdata_d = load_data;
        dumpaddr_d = index_q;
        state_d    = SEND;
      end
      SEND: begin
        if (dumpready) begin
          if (index_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            index_d = index_q + AW'(1);
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    dumpvalid_d = (state_d == SEND);
    dumpdone_d  = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

endmodule

// File: tb/tb_regfile_readback.sv
// Randomized self-checking bench for regfile_readback: one instance with the
// zero register hardwired, one without, driven by the same stimulus.
module tb_regfile_readback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regwrite;
  logic [3:0]  writereg;
  logic [15:0] writedata;
  logic [3:0]  readreg1, readreg2;
  logic        dumpreq, dumpready;

  logic [15:0] readdata1, readdata2;
  logic        dumpvalid, dumpdone, busy;
  logic [3:0]  dumpaddr;
  logic [15:0] dumpdata;

  logic [15:0] nz_readdata1, nz_readdata2;
  logic        nz_dumpvalid, nz_dumpdone, nz_busy;
  logic [3:0]  nz_dumpaddr;
  logic [15:0] nz_dumpdata;

  // reference register contents: m1 with zero register, m0 without
  logic [15:0] m1 [16];
  logic [15:0] m0 [16];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  regfile_readback #(.WIDTH(16), .NREG(16), .AW(4), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .regwrite(regwrite), .writereg(writereg),
    .writedata(writedata), .readreg1(readreg1), .readreg2(readreg2),
    .readdata1(readdata1), .readdata2(readdata2), .dumpreq(dumpreq),
    .dumpready(dumpready), .dumpvalid(dumpvalid), .dumpaddr(dumpaddr),
    .dumpdata(dumpdata), .dumpdone(dumpdone), .busy(busy)
  );

  regfile_readback #(.WIDTH(16), .NREG(16), .AW(4), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .regwrite(regwrite), .writereg(writereg),
    .writedata(writedata), .readreg1(readreg1), .readreg2(readreg2),
    .readdata1(nz_readdata1), .readdata2(nz_readdata2), .dumpreq(dumpreq),
    .dumpready(dumpready), .dumpvalid(nz_dumpvalid), .dumpaddr(nz_dumpaddr),
    .dumpdata(nz_dumpdata), .dumpdone(nz_dumpdone), .busy(nz_busy)
  );

  function automatic void clear_model();
    for (int i = 0; i < 16; i++) begin
      m1[i] = '0;
      m0[i] = '0;
    end
  endfunction

  // expected read-port value under the current input drive
  function automatic logic [15:0] exp_rd(input bit zr, input logic [3:0] a);
    if (zr && a == 4'd0) return 16'h0000;
    if (regwrite && writereg == a) return writedata;
    return zr ? m1[a] : m0[a];
  endfunction

  // one clock edge: model applies the write seen at the edge, then settle
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      clear_model();
    end else if (regwrite) begin
      m0[writereg] = writedata;
      if (writereg != 4'd0) m1[writereg] = writedata;
    end
    #1;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
    regwrite = 1'b1; writereg = a; writedata = d;
    tick();
    regwrite = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) write_reg(4'(i), 16'(i * 20));
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) write_reg(4'($urandom_range(1, 15)), 16'($urandom));
    dumpreq = 1'b1; tick(); dumpreq = 1'b0; tick(); tick();
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    total++; if (dumpvalid !== 1'b0) $display("FAIL reset_valid got %0b want 0", dumpvalid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
    total++; if (dumpdone !== 1'b0) $display("FAIL reset_done got %0b want 0", dumpdone); else passed++;
    total++; if (dumpaddr !== 4'd0 || dumpdata !== 16'd0)
      $display("FAIL reset_dump got addr %0h data %0h want 0 0", dumpaddr, dumpdata); else passed++;
    for (int a = 0; a < 16; a++) begin
      readreg1 = 4'(a); readreg2 = 4'(15 - a);
      #0.25;
      total++; if (readdata1 !== 16'd0 || nz_readdata2 !== 16'd0)
        $display("FAIL reset_read a=%0d got %0h %0h want 0 0", a, readdata1, nz_readdata2); else passed++;
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    write_reg(4'd3, 16'h1234);
    readreg1 = 4'd3; #1;
    total++; if (readdata1 !== 16'h1234) $display("FAIL wr_rd3 got %0h want 1234", readdata1); else passed++;
    regwrite = 1'b1; writereg = 4'd5; writedata = 16'hBEEF; readreg2 = 4'd5; #1;
    total++; if (readdata2 !== 16'hBEEF) $display("FAIL bypass5 got %0h want beef", readdata2); else passed++;
    tick();
    regwrite = 1'b0;
    for (int n = 0; n < 200; n++) begin
      regwrite  = 1'($urandom_range(0, 1));
      writereg  = 4'($urandom_range(0, 15));
      writedata = 16'($urandom);
      readreg1  = 4'($urandom_range(0, 15));
      readreg2  = ($urandom_range(0, 3) == 0) ? writereg : 4'($urandom_range(0, 15));
      #1;
      total++; if (readdata1 !== exp_rd(1'b1, readreg1) || readdata2 !== exp_rd(1'b1, readreg2))
        $display("FAIL rand_rd_z r1=%0d r2=%0d got %0h %0h want %0h %0h", readreg1, readreg2,
                 readdata1, readdata2, exp_rd(1'b1, readreg1), exp_rd(1'b1, readreg2)); else passed++;
      total++; if (nz_readdata1 !== exp_rd(1'b0, readreg1) || nz_readdata2 !== exp_rd(1'b0, readreg2))
        $display("FAIL rand_rd_nz r1=%0d r2=%0d got %0h %0h want %0h %0h", readreg1, readreg2,
                 nz_readdata1, nz_readdata2, exp_rd(1'b0, readreg1), exp_rd(1'b0, readreg2)); else passed++;
      tick();
    end
    regwrite = 1'b0;
  endtask

  task automatic test_zero_reg();
    write_reg(4'd0, 16'hFFFF);
    readreg1 = 4'd0; #1;
    total++; if (readdata1 !== 16'h0000) $display("FAIL zero_rd got %0h want 0000", readdata1); else passed++;
    total++; if (nz_readdata1 !== 16'hFFFF) $display("FAIL nz_rd0 got %0h want ffff", nz_readdata1); else passed++;
    regwrite = 1'b1; writereg = 4'd0; writedata = 16'h5A5A; readreg2 = 4'd0; #1;
    total++; if (readdata2 !== 16'h0000) $display("FAIL zero_bypass got %0h want 0000", readdata2); else passed++;
    total++; if (nz_readdata2 !== 16'h5A5A) $display("FAIL nz_bypass0 got %0h want 5a5a", nz_readdata2); else passed++;
    tick();
    regwrite = 1'b0;
  endtask

  // mode 0: ready high, 1: random ready, 2: stall beat 7 for 5 cycles
  task automatic run_dump(input int mode, input bit wr, input bit pulse_req);
    int edge_n = 1, first_valid = 0, done_edge = 0, beat = 0, stall = 0;
    logic prev_valid = 1'b0;
    logic accept;
    logic [3:0]  held_addr = '0;
    logic [15:0] held_data = '0;
    regwrite = 1'b0; dumpready = 1'b1; dumpreq = 1'b1;
    tick();
    dumpreq = 1'b0;
    total++; if (busy !== 1'b1 || dumpvalid !== 1'b0)
      $display("FAIL dump_start got busy %0b valid %0b want 1 0", busy, dumpvalid); else passed++;
    while (edge_n < 400 && done_edge == 0) begin
      dumpready = 1'b1;
      regwrite  = 1'b0;
      if (mode == 1) dumpready = 1'($urandom_range(0, 1));
      if (mode == 2 && dumpvalid && dumpaddr == 4'd7 && stall < 5) begin
        dumpready = 1'b0;
        regwrite = 1'b1; writereg = 4'd7; writedata = 16'(16'hABCD + stall);
        stall++;
      end else if (wr) begin
        regwrite  = 1'($urandom_range(0, 1));
        writereg  = 4'($urandom_range(0, 15));
        writedata = 16'($urandom);
      end
      if (pulse_req) dumpreq = 1'($urandom_range(0, 1));
      accept = dumpvalid && dumpready;
      tick();
      edge_n++;
      regwrite = 1'b0;
      dumpreq  = 1'b0;
      if (accept) beat++;
      if (dumpvalid) begin
        if (first_valid == 0) first_valid = edge_n;
        if (!prev_valid) begin
          total++; if (dumpaddr !== 4'(beat) || dumpdata !== m1[4'(beat)])
            $display("FAIL beat%0d got addr %0h data %0h want %0h %0h", beat, dumpaddr, dumpdata,
                     4'(beat), m1[4'(beat)]); else passed++;
          total++; if (nz_dumpvalid !== 1'b1 || nz_dumpaddr !== 4'(beat) || nz_dumpdata !== m0[4'(beat)])
            $display("FAIL nz_beat%0d got v %0b addr %0h data %0h want 1 %0h %0h", beat, nz_dumpvalid,
                     nz_dumpaddr, nz_dumpdata, 4'(beat), m0[4'(beat)]); else passed++;
          if (mode == 0 && !wr) begin
            total++; if (dumpdata !== 16'(beat * 20))
              $display("FAIL preload_beat%0d got %0h want %0h", beat, dumpdata, 16'(beat * 20)); else passed++;
          end
          held_addr = dumpaddr;
          held_data = dumpdata;
        end else begin
          total++; if (dumpaddr !== held_addr || dumpdata !== held_data)
            $display("FAIL hold_beat%0d got %0h %0h want %0h %0h", beat, dumpaddr, dumpdata,
                     held_addr, held_data); else passed++;
        end
      end
      if (dumpdone) begin
        done_edge = edge_n;
        total++; if (dumpvalid !== 1'b0 || nz_dumpdone !== 1'b1)
          $display("FAIL done_flags got valid %0b nzdone %0b want 0 1", dumpvalid, nz_dumpdone); else passed++;
      end else begin
        total++; if (busy !== 1'b1 || nz_busy !== 1'b1)
          $display("FAIL busy_mid got %0b %0b want 1 1", busy, nz_busy); else passed++;
      end
      prev_valid = dumpvalid;
    end
    total++; if (done_edge == 0 || beat != 16)
      $display("FAIL dump_end got done_edge %0d beats %0d want >0 16", done_edge, beat); else passed++;
    if (mode == 0) begin
      total++; if (first_valid != 2 || done_edge != 33)
        $display("FAIL dump_timing got first %0d done %0d want 2 33", first_valid, done_edge); else passed++;
    end
    if (mode == 2) begin
      total++; if (stall != 5) $display("FAIL stall_count got %0d want 5", stall); else passed++;
    end
    tick();
    total++; if (dumpdone !== 1'b0 || busy !== 1'b0)
      $display("FAIL after_done got done %0b busy %0b want 0 0", dumpdone, busy); else passed++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL no_requeue got busy %0b want 0", busy); else passed++;
  endtask

  task automatic test_dump();
    preload();
    run_dump(0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    preload();
    run_dump(2, 1'b0, 1'b0);
  endtask

  task automatic test_random_dump();
    for (int n = 0; n < 4; n++) run_dump(1, 1'b1, 1'b1);
  endtask

  task automatic test_retrigger();
    int n = 0;
    dumpready = 1'b1; dumpreq = 1'b1;
    tick();
    while (!dumpdone && n < 60) begin tick(); n++; end
    total++; if (dumpdone !== 1'b1) $display("FAIL retrig_first got done %0b want 1", dumpdone); else passed++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL retrig_idle got busy %0b want 0", busy); else passed++;
    tick();
    total++; if (busy !== 1'b1) $display("FAIL retrig_start got busy %0b want 1", busy); else passed++;
    dumpreq = 1'b0;
    n = 0;
    while (!dumpdone && n < 60) begin tick(); n++; end
    total++; if (dumpdone !== 1'b1) $display("FAIL retrig_second got done %0b want 1", dumpdone); else passed++;
    tick(); tick();
  endtask

  task automatic test_abort();
    int n = 0;
    preload();
    dumpready = 1'b1; dumpreq = 1'b1;
    tick();
    dumpreq = 1'b0;
    while (!(dumpvalid && dumpaddr == 4'd4) && n < 40) begin tick(); n++; end
    total++; if (dumpvalid !== 1'b1 || dumpaddr !== 4'd4)
      $display("FAIL abort_reach got valid %0b addr %0h want 1 4", dumpvalid, dumpaddr); else passed++;
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    total++; if (dumpvalid !== 1'b0 || busy !== 1'b0 || dumpdone !== 1'b0)
      $display("FAIL abort_clear got v %0b b %0b d %0b want 0 0 0", dumpvalid, busy, dumpdone); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (dumpdone !== 1'b0 || dumpvalid !== 1'b0)
        $display("FAIL abort_hold got d %0b v %0b want 0 0", dumpdone, dumpvalid); else passed++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (dumpdone !== 1'b0 || busy !== 1'b0)
        $display("FAIL abort_after got d %0b b %0b want 0 0", dumpdone, busy); else passed++;
    end
    readreg1 = 4'd9; #1;
    total++; if (nz_readdata1 !== 16'd0) $display("FAIL abort_regs got %0h want 0", nz_readdata1); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; regwrite = 1'b0; writereg = '0; writedata = '0;
    readreg1 = '0; readreg2 = '0; dumpreq = 1'b0; dumpready = 1'b0;
    clear_model();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_dump();
    test_backpressure();
    test_random_dump();
    test_retrigger();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
